// File: rtl/policy_rom_arbiter_if.sv
// Agent-side bundle for the policy ROM arbiter: per-agent requests, grants,
// response pulses and the held lookup results / paddle actions.
interface policy_rom_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 2
);
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ*DATA_W-1:0] rsp_data;
    logic [NREQ*3-1:0]      action;

    // Agents drive requests and observe grants/results.
    modport master (
        output req, req_addr,
        input  gnt, rsp_valid, rsp_data, action
    );

    // The arbiter samples requests and drives grants/results.
    modport slave (
        input  req, req_addr,
        output gnt, rsp_valid, rsp_data, action
    );
endinterface

// File: rtl/policy_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous-read policy ROM between
// several paddle-AI agents. Each lookup occupies ROM_LAT+2 cycles:
// grant (IDLE), ROM_LAT cycles of latency countdown, then capture.
module policy_rom_arbiter #(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 2,
    parameter int ROM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    policy_rom_arbiter_if.slave agt,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_data,
    output logic                busy
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_id;
    logic [CNT_W-1:0]    r_cnt;
    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     r_rsp_valid;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [DATA_W-1:0]   r_hold [NREQ];

    logic                w_found;
    logic [PTR_W-1:0]    w_win;
    logic [ADDR_W-1:0]   w_win_addr;

    // Round-robin winner search: first set request at or after r_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        w_found    = 1'b0;
        w_win      = '0;
        w_win_addr = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(r_ptr) + k) % NREQ;
            if (!w_found && agt.req[idx]) begin
                w_found    = 1'b1;
                w_win      = PTR_W'(idx);
                w_win_addr = agt.req_addr[idx*ADDR_W +: ADDR_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: grant leaves IDLE, countdown reaches CAPTURE, capture returns.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_found) w_next = S_WAIT;
            S_WAIT:    if (r_cnt == CNT_W'(1)) w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        busy = (r_state != S_IDLE);
    end

    // Datapath: grant bookkeeping, latency counter, pulses and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_id        <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rom_addr  <= '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_rom_addr   <= w_win_addr;
                        r_id         <= w_win;
                        r_gnt[w_win] <= 1'b1;
                        r_cnt        <= CNT_W'(ROM_LAT);
                        r_ptr        <= (32'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                end
                S_CAPTURE: begin
                    r_hold[r_id]      <= rom_data;
                    r_rsp_valid[r_id] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign agt.gnt       = r_gnt;
    assign agt.rsp_valid = r_rsp_valid;
    assign rom_addr      = r_rom_addr;

    for (genvar i = 0; i < NREQ; i++) begin : g_out
        assign agt.rsp_data[i*DATA_W +: DATA_W] = r_hold[i];
        assign agt.action[i*3 +: 3]             = 3'(r_hold[i]) + 3'd1;
    end
endmodule

// File: tb/tb_policy_rom_arbiter.sv
// Self-checking bench: DUT A (NREQ=2, ROM_LAT=1) with table vectors, hand
// sequences and randomized traffic against a schedule-level model;
// DUT B (NREQ=4, ROM_LAT=3) with a directed latency sequence.
module tb_policy_rom_arbiter;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    policy_rom_arbiter_if #(.NREQ(2), .ADDR_W(16), .DATA_W(2)) ifa ();
    policy_rom_arbiter_if #(.NREQ(4), .ADDR_W(16), .DATA_W(2)) ifb ();

    logic [15:0] rom_addr_a, rom_addr_b;
    logic [1:0]  rom_data_a, rom_data_b;
    logic        busy_a, busy_b;

    policy_rom_arbiter #(.NREQ(2), .ADDR_W(16), .DATA_W(2), .ROM_LAT(LAT_A)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .agt      (ifa.slave),
        .rom_addr (rom_addr_a),
        .rom_data (rom_data_a),
        .busy     (busy_a)
    );

    policy_rom_arbiter #(.NREQ(4), .ADDR_W(16), .DATA_W(2), .ROM_LAT(LAT_B)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .agt      (ifb.slave),
        .rom_addr (rom_addr_b),
        .rom_data (rom_data_b),
        .busy     (busy_b)
    );

    // ROM models: code = addr[1:0], delivered ROM_LAT edges after sampling.
    always @(posedge clk) rom_data_a <= rom_addr_a[1:0];

    logic [1:0] rb [LAT_B];
    always @(posedge clk) begin
        rb[0] <= rom_addr_b[1:0];
        for (int i = 1; i < LAT_B; i++) rb[i] <= rb[i-1];
    end
    assign rom_data_b = rb[LAT_B-1];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] act2(input logic [1:0] h1, input logic [1:0] h0);
        logic [2:0] a1, a0;
        a1 = 3'(h1) + 3'd1;
        a0 = 3'(h0) + 3'd1;
        return {a1, a0};
    endfunction

    typedef struct {
        logic [1:0]  req;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [1:0]  gnt;
        logic [1:0]  code;
    } vec_t;

    vec_t       tv [7];
    logic [1:0] he [2];

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ifa.req = '0; ifa.req_addr = '0;
        ifb.req = '0; ifb.req_addr = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        ifa.req = '0; ifa.req_addr = '0;
        ifb.req = '0; ifb.req_addr = '0;

        // Power-up reset values (asynchronous assertion).
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gnt_a",   ifa.gnt, 2'b00);
        chk("rst_rv_a",    ifa.rsp_valid, 2'b00);
        chk("rst_addr_a",  rom_addr_a, 16'h0000);
        chk("rst_data_a",  ifa.rsp_data, 4'h0);
        chk("rst_act_a",   ifa.action, 6'b001_001);
        chk("rst_busy_a",  busy_a, 1'b0);
        chk("rst_act_b",   ifb.action, 12'b001_001_001_001);
        chk("rst_busy_b",  busy_b, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors on DUT A; ptr starts at 0.
        tv[0] = '{2'b01, 16'h0006, 16'h0000, 2'b01, 2'd2};
        tv[1] = '{2'b11, 16'h0001, 16'h0003, 2'b10, 2'd3};
        tv[2] = '{2'b11, 16'h0001, 16'h0003, 2'b01, 2'd1};
        tv[3] = '{2'b01, 16'h0100, 16'hFFFF, 2'b01, 2'd0};
        tv[4] = '{2'b10, 16'h1234, 16'h0002, 2'b10, 2'd2};
        tv[5] = '{2'b10, 16'h0000, 16'hA5A7, 2'b10, 2'd3};
        tv[6] = '{2'b00, 16'h0003, 16'h0003, 2'b00, 2'd0};
        he[0] = 2'd0; he[1] = 2'd0;

        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            ifa.req      = tv[v].req;
            ifa.req_addr = {tv[v].a1, tv[v].a0};
            @(posedge clk); #1;
            chk("tv_gnt", ifa.gnt, tv[v].gnt);
            chk("tv_busy_e0", busy_a, tv[v].gnt != 2'b00);
            if (tv[v].gnt != 2'b00)
                chk("tv_rom_addr", rom_addr_a, tv[v].gnt[0] ? tv[v].a0 : tv[v].a1);
            @(negedge clk);
            ifa.req      = '0;
            ifa.req_addr = {16'($urandom), 16'($urandom)};
            @(posedge clk); #1;
            chk("tv_rv_e1", ifa.rsp_valid, 2'b00);
            @(posedge clk); #1;
            if (tv[v].gnt[0]) he[0] = tv[v].code;
            if (tv[v].gnt[1]) he[1] = tv[v].code;
            chk("tv_rv_e2", ifa.rsp_valid, tv[v].gnt);
            chk("tv_data",  ifa.rsp_data, {he[1], he[0]});
            chk("tv_action", ifa.action, act2(he[1], he[0]));
            chk("tv_busy_e2", busy_a, 1'b0);
        end

        // Single agent holding req: grants every ROM_LAT+2 = 3 edges.
        @(negedge clk);
        ifa.req      = 2'b10;
        ifa.req_addr = {16'h0005, 16'h0000};
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            chk("b2b_gnt", ifa.gnt, (c % 3 == 0) ? 2'b10 : 2'b00);
            chk("b2b_rv",  ifa.rsp_valid, (c % 3 == 2) ? 2'b10 : 2'b00);
        end
        he[1] = 2'd1;
        chk("b2b_data", ifa.rsp_data, {he[1], he[0]});
        @(negedge clk);
        ifa.req = '0;
        repeat (3) @(posedge clk);

        // Reset in the middle of a lookup discards it.
        @(negedge clk);
        ifa.req      = 2'b01;
        ifa.req_addr = {16'h0000, 16'h0003};
        @(posedge clk); #1;
        chk("mid_gnt", ifa.gnt, 2'b01);
        @(negedge clk);
        ifa.req = '0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt",  ifa.gnt, 2'b00);
        chk("mid_rst_rv",   ifa.rsp_valid, 2'b00);
        chk("mid_rst_addr", rom_addr_a, 16'h0000);
        chk("mid_rst_busy", busy_a, 1'b0);
        chk("mid_rst_data", ifa.rsp_data, 4'h0);
        chk("mid_rst_act",  ifa.action, 6'b001_001);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("post_rst_rv",   ifa.rsp_valid, 2'b00);
            chk("post_rst_data", ifa.rsp_data, 4'h0);
        end

        // DUT B: ROM_LAT=3, agent 3; address changes right after the grant.
        @(negedge clk);
        ifb.req      = 4'b1000;
        ifb.req_addr = {16'h00AB, 16'h0001, 16'h0002, 16'h0000};
        @(posedge clk); #1;
        chk("b_gnt",  ifb.gnt, 4'b1000);
        chk("b_addr", rom_addr_b, 16'h00AB);
        @(negedge clk);
        ifb.req      = '0;
        ifb.req_addr = {16'h0004, 16'h0001, 16'h0002, 16'h0000};
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            chk("b_rv_wait", ifb.rsp_valid, 4'b0000);
            chk("b_busy",    busy_b, 1'b1);
            chk("b_addr_hold", rom_addr_b, 16'h00AB);
        end
        @(posedge clk); #1;
        chk("b_rv",     ifb.rsp_valid, 4'b1000);
        chk("b_data",   ifb.rsp_data, 8'b11_00_00_00);
        chk("b_action", ifb.action, {3'd4, 3'd1, 3'd1, 3'd1});
        chk("b_idle",   busy_b, 1'b0);
        @(posedge clk); #1;
        chk("b_rv_clr", ifb.rsp_valid, 4'b0000);

        // Randomized traffic on DUT A against a schedule-level model.
        do_reset();
        begin
            int          e, free_at, mptr, g_edge, rsp_edge, rsp_w, w;
            logic [1:0]  rsp_code, req_s, exp_gnt, exp_rv, mh0, mh1;
            logic [15:0] last_addr, sa [2];
            logic        exp_busy;
            e = 0; free_at = 0; mptr = 0; g_edge = -100; rsp_edge = -1;
            rsp_w = 0; rsp_code = '0; last_addr = '0; mh0 = '0; mh1 = '0;
            for (int n = 0; n < 600; n++) begin
                @(negedge clk);
                if ($urandom_range(0, 3) == 0) ifa.req = 2'($urandom_range(0, 3));
                ifa.req_addr = {16'($urandom), 16'($urandom)};
                req_s = ifa.req;
                sa[0] = ifa.req_addr[15:0];
                sa[1] = ifa.req_addr[31:16];
                @(posedge clk);
                exp_gnt = '0;
                exp_rv  = '0;
                if (rsp_edge == e) begin
                    if (rsp_w == 0) mh0 = rsp_code; else mh1 = rsp_code;
                    exp_rv[rsp_w] = 1'b1;
                end
                if (e >= free_at && req_s != 2'b00) begin
                    w = req_s[mptr] ? mptr : (mptr + 1) % 2;
                    exp_gnt[w] = 1'b1;
                    last_addr  = sa[w];
                    rsp_edge   = e + LAT_A + 1;
                    rsp_w      = w;
                    rsp_code   = last_addr[1:0];
                    free_at    = e + LAT_A + 2;
                    mptr       = (w + 1) % 2;
                    g_edge     = e;
                end
                exp_busy = (e >= g_edge) && (e < g_edge + LAT_A + 1);
                #1;
                chk("rnd_gnt",    ifa.gnt, exp_gnt);
                chk("rnd_rv",     ifa.rsp_valid, exp_rv);
                chk("rnd_addr",   rom_addr_a, last_addr);
                chk("rnd_data",   ifa.rsp_data, {mh1, mh0});
                chk("rnd_action", ifa.action, act2(mh1, mh0));
                chk("rnd_busy",   busy_a, exp_busy);
                e++;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
